// File: rtl/uart_sort_pkg.sv
// Shared state type, constants and length check for the UART sort sequencer.
package uart_sort_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_ERR
    } state_t;

    localparam logic [7:0] ERR_BYTE  = 8'hEE;
    localparam int         DEPTH_MAX = 64;

    // A length byte is usable when it names at least one byte and fits the array.
    function automatic bit length_ok(input logic [7:0] len, input int depth);
        return (len != 8'd0) && (int'(len) <= depth);
    endfunction

endpackage

// File: rtl/uart_sort_insert_array.sv
// Sorted register array: each insert compares against every live slot and shifts
// the larger elements up one place, so the contents stay in ascending order.
module uart_sort_insert_array
    import uart_sort_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       clear,
    input  logic                       ins_en,
    input  logic [7:0]                 ins_data,
    input  logic [$clog2(DEPTH+1)-1:0] count,
    input  logic [$clog2(DEPTH+1)-1:0] rd_idx,
    output logic [7:0]                 rd_data
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]       slot    [DEPTH];
    logic [7:0]       shifted [DEPTH];
    logic [DEPTH-1:0] keep;

    // keep[i] marks live slots <= the new byte; equal elements stay below it,
    // which keeps duplicates in arrival order.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            keep[i] = (CW'(i) < count) && (slot[i] <= ins_data);
        end
        shifted[0] = keep[0] ? slot[0] : ins_data;
        for (int i = 1; i < DEPTH; i++) begin
            if (keep[i]) begin
                shifted[i] = slot[i];
            end else if (keep[i-1]) begin
                shifted[i] = ins_data;
            end else begin
                shifted[i] = slot[i-1];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_idx == CW'(i)) begin
                rd_data = slot[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= '0;
            end
        end else if (ins_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot[i] <= shifted[i];
            end
        end
    end

endmodule

// File: rtl/uart_sort_sequencer.sv
// Receives a length-prefixed frame, replies with its bytes in ascending order.
// Define UART_SORT_ERR_REPLY_EN to answer a rejected length byte with one EE byte.
module uart_sort_sequencer
    import uart_sort_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       rx_ready_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       err_o
);

    localparam int CW = $clog2(DEPTH + 1);

    state_t        state;
    logic [CW-1:0] len;
    logic [CW-1:0] count;
    logic [CW-1:0] idx;
    logic          ready;
    logic          valid;
    logic          busy;
    logic          err;
    logic          rx_fire;
    logic          tx_fire;
    logic          last_fire;
    logic          ins_en;
    logic          clear;
    logic [7:0]    rd_data;

    // Ready is held low while reset is asserted so nothing is accepted mid-reset.
    assign rx_ready_o = ready & ~rst_i;
    assign tx_valid_o = valid;
    assign busy_o     = busy;
    assign err_o      = err;

    assign rx_fire   = rx_valid_i & rx_ready_o;
    assign tx_fire   = valid & tx_ready_i;
    assign last_fire = tx_fire && (state == ST_SEND) && (idx == len - CW'(1));
    assign ins_en    = rx_fire && (state == ST_LOAD);
    assign clear     = rst_i | last_fire;

`ifdef UART_SORT_ERR_REPLY_EN
    assign tx_data_o = (state == ST_ERR) ? ERR_BYTE : rd_data;
`else
    assign tx_data_o = rd_data;
`endif

    uart_sort_insert_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk      (clk_i),
        .clear    (clear),
        .ins_en   (ins_en),
        .ins_data (rx_data_i),
        .count    (count),
        .rd_idx   (idx),
        .rd_data  (rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            len   <= '0;
            count <= '0;
            idx   <= '0;
            ready <= 1'b1;
            valid <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rx_fire) begin
                        busy <= 1'b1;
                        if (length_ok(rx_data_i, DEPTH)) begin
                            state <= ST_LOAD;
                            len   <= CW'(rx_data_i);
                            count <= '0;
                        end else begin
                            state <= ST_ERR;
                            err   <= 1'b1;
                            ready <= 1'b0;
`ifdef UART_SORT_ERR_REPLY_EN
                            valid <= 1'b1;
`endif
                        end
                    end
                end
                ST_LOAD: begin
                    if (rx_fire) begin
                        count <= count + CW'(1);
                        if (count + CW'(1) == len) begin
                            state <= ST_SEND;
                            ready <= 1'b0;
                            valid <= 1'b1;
                            idx   <= '0;
                        end
                    end
                end
                ST_SEND: begin
                    if (last_fire) begin
                        state <= ST_IDLE;
                        count <= '0;
                        idx   <= '0;
                        valid <= 1'b0;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end else if (tx_fire) begin
                        idx <= idx + CW'(1);
                    end
                end
                ST_ERR: begin
`ifdef UART_SORT_ERR_REPLY_EN
                    if (tx_fire) begin
                        state <= ST_IDLE;
                        valid <= 1'b0;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                    end
`else
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
`endif
                end
                default: begin
                    state <= ST_IDLE;
                    ready <= 1'b1;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_sort_sequencer.sv
// Bench for uart_sort_sequencer: frame-level reference model plus directed and random frames.
module tb_uart_sort_sequencer;

    localparam int DEPTH  = 16;
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       rx_valid_i;
    logic [7:0] rx_data_i;
    logic       rx_ready_o;
    logic       tx_valid_o;
    logic [7:0] tx_data_o;
    logic       tx_ready_i;
    logic       busy_o;
    logic       err_o;

    always #5 clk = ~clk;

    uart_sort_sequencer #(
        .DEPTH (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .rx_valid_i (rx_valid_i),
        .rx_data_i  (rx_data_i),
        .rx_ready_o (rx_ready_o),
        .tx_valid_o (tx_valid_o),
        .tx_data_o  (tx_data_o),
        .tx_ready_i (tx_ready_i),
        .busy_o     (busy_o),
        .err_o      (err_o)
    );

    int vectors     = 0;
    int miscompares = 0;

    // stimulus controls
    logic [7:0] src [$];
    int gap_pct = 0;
    int tx_mode = 1;

    // reference model: 0 idle, 1 collecting, 2 replying, 3 rejected length
    int         phase    = 0;
    int         m_len    = 0;
    bit         m_err    = 1'b0;
    bit         model_on = 1'b0;
    int         cyc      = 0;
    logic [7:0] frame [$];
    logic [7:0] reply [$];

    // observations of the DUT
    logic [7:0] log_q [$];
    logic [7:0] want  [$];
    int rx_acc      = 0;
    int err_pulses  = 0;
    int rx_in_send  = 0;
    int last_rx_cyc = 0;
    int rise_cyc    = 0;
    bit prev_txv    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit exp_ready();
        return !rst_i && (phase == 0 || phase == 1);
    endfunction

    function automatic bit exp_valid();
`ifdef UART_SORT_ERR_REPLY_EN
        return (phase == 2) || (phase == 3);
`else
        return (phase == 2);
`endif
    endfunction

    function automatic int exp_data();
        if (phase == 2 && reply.size() > 0) return int'(reply[0]);
        return 32'hEE;
    endfunction

    function automatic void sort_frame();
        logic [7:0] t;
        reply = frame;
        for (int i = 0; i < reply.size(); i++) begin
            for (int j = i + 1; j < reply.size(); j++) begin
                if (reply[j] < reply[i]) begin
                    t        = reply[i];
                    reply[i] = reply[j];
                    reply[j] = t;
                end
            end
        end
    endfunction

    // model update on the active edge, from the inputs and the model's own outputs
    always @(posedge clk) begin : model_p
        bit rf;
        bit tf;
        rf = exp_ready() && rx_valid_i;
        tf = exp_valid() && tx_ready_i;
        cyc++;
        if (rst_i) begin
            phase    = 0;
            m_err    = 1'b0;
            model_on = 1'b1;
            frame.delete();
            reply.delete();
        end else begin
            m_err = 1'b0;
            if (rf && src.size() > 0) void'(src.pop_front());
            case (phase)
                0: if (rf) begin
                    if (rx_data_i >= 8'd1 && int'(rx_data_i) <= DEPTH) begin
                        m_len = int'(rx_data_i);
                        frame.delete();
                        phase = 1;
                    end else begin
                        m_err = 1'b1;
                        phase = 3;
                    end
                end
                1: if (rf) begin
                    frame.push_back(rx_data_i);
                    if (frame.size() == m_len) begin
                        sort_frame();
                        phase = 2;
                    end
                end
                2: if (tf) begin
                    void'(reply.pop_front());
                    if (reply.size() == 0) phase = 0;
                end
                default: begin
`ifdef UART_SORT_ERR_REPLY_EN
                    if (tf) phase = 0;
`else
                    phase = 0;
`endif
                end
            endcase
        end
    end

    // input driver, one step after each active edge
    initial begin
        rst_i      = 1'b1;
        rx_valid_i = 1'b0;
        rx_data_i  = 8'h00;
        tx_ready_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (src.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
                rx_valid_i = 1'b1;
                rx_data_i  = src[0];
            end else begin
                rx_valid_i = 1'b0;
                rx_data_i  = 8'($urandom);
            end
            case (tx_mode)
                0:       tx_ready_i = 1'b0;
                1:       tx_ready_i = 1'b1;
                default: tx_ready_i = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // per-cycle comparison against the model, sampled on the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("rx_ready", int'(rx_ready_o), int'(exp_ready()));
                check("tx_valid", int'(tx_valid_o), int'(exp_valid()));
                check("busy", int'(busy_o), int'(phase != 0));
                check("err", int'(err_o), int'(m_err));
                if (exp_valid()) check("tx_data", int'(tx_data_o), exp_data());
                if (rx_valid_i && rx_ready_o) begin
                    rx_acc++;
                    last_rx_cyc = cyc;
                    if (tx_valid_o) rx_in_send++;
                end
                if (tx_valid_o && tx_ready_i) log_q.push_back(tx_data_o);
                if (tx_valid_o && !prev_txv) rise_cyc = cyc;
                prev_txv = tx_valid_o;
                if (err_o) err_pulses++;
            end
        end
    end

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((src.size() > 0 || phase != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: no return to idle within %0d cycles", name, budget);
        end
        repeat (2) @(negedge clk);
        #1;
    endtask

    task automatic check_log(input string name);
        check({name, "_count"}, log_q.size(), want.size());
        for (int i = 0; i < log_q.size() && i < want.size(); i++) begin
            check(name, int'(log_q[i]), int'(want[i]));
        end
    endtask

    initial begin
        logic [7:0] bad [2];
        int base;
        int n;
        int total;
        int len;
        bad[0] = 8'h00;
        bad[1] = 8'h11;

        repeat (3) @(negedge clk);
        #1;
        check("rst_rx_ready", int'(rx_ready_o), 0);
        rst_i = 1'b0;
        @(negedge clk);
        #1;
        check("rst_rx_ready_idle", int'(rx_ready_o), 1);
        check("rst_tx_valid", int'(tx_valid_o), 0);
        check("rst_tx_data", int'(tx_data_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_err", int'(err_o), 0);

        // 04,09,03,07,03 -> 03,03,07,09
        log_q.delete();
        base = rx_acc;
        src.push_back(8'h04); src.push_back(8'h09); src.push_back(8'h03);
        src.push_back(8'h07); src.push_back(8'h03);
        wait_idle("f1", 500);
        check("f1_accepts", rx_acc - base, 5);
        want.delete();
        want.push_back(8'h03); want.push_back(8'h03); want.push_back(8'h07); want.push_back(8'h09);
        check_log("f1");
        check("f1_busy", int'(busy_o), 0);

        // single-byte frame and first-tx latency
        log_q.delete();
        src.push_back(8'h01); src.push_back(8'h5A);
        wait_idle("f2", 500);
        want.delete();
        want.push_back(8'h5A);
        check_log("f2");
        check("f2_latency", rise_cyc - last_rx_cyc, 1);

        // back-pressure during the reply
        log_q.delete();
        tx_mode = 0;
        src.push_back(8'h03); src.push_back(8'h10); src.push_back(8'h20); src.push_back(8'h30);
        n = 0;
        while (phase != 2 && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (5) @(negedge clk);
        #1;
        check("f3_hold_valid", int'(tx_valid_o), 1);
        check("f3_hold_data", int'(tx_data_o), 8'h10);
        tx_mode = 1;
        wait_idle("f3", 500);
        want.delete();
        want.push_back(8'h10); want.push_back(8'h20); want.push_back(8'h30);
        check_log("f3");

        // rejected length bytes, then a normal frame
        for (int b = 0; b < 2; b++) begin
            log_q.delete();
            base = err_pulses;
            src.push_back(bad[b]);
            wait_idle("bad_len", 500);
            check("bad_err_pulses", err_pulses - base, 1);
            want.delete();
`ifdef UART_SORT_ERR_REPLY_EN
            want.push_back(8'hEE);
`endif
            check_log("bad_reply");
            log_q.delete();
            src.push_back(8'h02); src.push_back(8'hFF); src.push_back(8'h00);
            wait_idle("after_bad", 500);
            want.delete();
            want.push_back(8'h00); want.push_back(8'hFF);
            check_log("after_bad");
        end

        // reset after two of four data bytes
        src.push_back(8'h04); src.push_back(8'hAA); src.push_back(8'hBB);
        n = 0;
        while (src.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        src.delete();
        rst_i = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_rx_ready", int'(rx_ready_o), 0);
        rst_i = 1'b0;
        log_q.delete();
        src.push_back(8'h02); src.push_back(8'h01); src.push_back(8'h02);
        wait_idle("midrst", 500);
        want.delete();
        want.push_back(8'h01); want.push_back(8'h02);
        check_log("midrst");

        // back-to-back frames with rx_valid held high
        log_q.delete();
        base = rx_in_send;
        src.push_back(8'h03); src.push_back(8'h33); src.push_back(8'h11); src.push_back(8'h22);
        src.push_back(8'h02); src.push_back(8'h80); src.push_back(8'h7F);
        src.push_back(8'h01); src.push_back(8'h44);
        wait_idle("b2b", 1000);
        check("b2b_rx_in_send", rx_in_send - base, 0);
        want.delete();
        want.push_back(8'h11); want.push_back(8'h22); want.push_back(8'h33);
        want.push_back(8'h7F); want.push_back(8'h80); want.push_back(8'h44);
        check_log("b2b");

        // random frames with random gaps and back-pressure
        log_q.delete();
        gap_pct = 25;
        tx_mode = 2;
        total   = 0;
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(0, DEPTH + 2);
            src.push_back(8'(len));
            if (len >= 1 && len <= DEPTH) begin
                for (int k = 0; k < len; k++) src.push_back(8'($urandom));
                total += len;
            end else begin
`ifdef UART_SORT_ERR_REPLY_EN
                total += 1;
`endif
            end
        end
        wait_idle("random", BUDGET);
        check("random_bytes", log_q.size(), total);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
